// File: rtl/mmu_port_arbiter.sv
// Shares one MMU request port between the data path (D) and the fetch path (I).
// Latency: mem_request rises one edge after a pending request is seen in IDLE; min 4 cycles IDLE->IDLE.
// Backpressure: a requester waits on x_busy; the MMU throttles via mem_busy, bounded by a timeout abort.
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate grants on a tie (default: D always wins).
module mmu_port_arbiter #(
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  // data load/store port
  input  logic [BUS_WIDTH-1:0] d_addr,
  input  logic                 d_request,
  input  logic                 d_write_enable,
  input  logic [BUS_WIDTH-1:0] d_data_in,
  output logic [BUS_WIDTH-1:0] d_out,
  output logic                 d_busy,
  // opcode fetch port (read-only)
  input  logic [BUS_WIDTH-1:0] i_addr,
  input  logic                 i_request,
  output logic [BUS_WIDTH-1:0] i_out,
  output logic                 i_busy,
  // shared MMU port
  output logic [BUS_WIDTH-1:0] mem_addr,
  output logic                 mem_request,
  output logic                 mem_write_enable,
  output logic [BUS_WIDTH-1:0] mem_data_in,
  input  logic [BUS_WIDTH-1:0] mem_out,
  input  logic                 mem_busy,
  // status
  output logic                 grant,
  output logic [1:0]           timeout_error
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]     CNT_MAX   = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [BUS_WIDTH-1:0] ABORT_VAL = BUS_WIDTH'(32'hDEADBEEF);

  // grant encoding
  localparam logic GNT_D = 1'b0;
  localparam logic GNT_I = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             served_d;
  logic             served_i;
  logic             pending_d;
  logic             pending_i;
  logic             pick_i;
  logic             any_pending;
  logic             granted_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic             last_grant;
`endif

  // A port is pending until its completed access has been acknowledged by
  // the requester dropping its request line.
  assign pending_d   = d_request & ~served_d;
  assign pending_i   = i_request & ~served_i;
  assign any_pending = pending_d | pending_i;

  // Busy drops during the single RESP cycle of the owning port, and also as
  // soon as the requester abandons its request.
  assign d_busy = pending_d & ~((state == ST_RESP) & (grant == GNT_D));
  assign i_busy = pending_i & ~((state == ST_RESP) & (grant == GNT_I));

  // Whether the owner of the current access still wants the result.
  assign granted_req = (grant == GNT_I) ? i_request : d_request;

  // Arbitration choice: I wins only when D is idle, or on a tie when D was the last owner.
  always_comb begin
    pick_i = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    if (pending_i && (!pending_d || (last_grant == GNT_D))) begin
      pick_i = 1'b1;
    end
`else
    if (pending_i && !pending_d) begin
      pick_i = 1'b1;
    end
`endif
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember who got the MMU last; resets to I so the first tie goes to D.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= GNT_I;
    end else if ((state == ST_IDLE) && any_pending) begin
      last_grant <= pick_i;
    end
  end
`endif

  // Served flags: set when the owner leaves RESP still requesting, cleared once the request drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      served_d <= 1'b0;
      served_i <= 1'b0;
    end else begin
      if (!d_request) begin
        served_d <= 1'b0;
      end else if ((state == ST_RESP) && (grant == GNT_D)) begin
        served_d <= 1'b1;
      end
      if (!i_request) begin
        served_i <= 1'b0;
      end else if ((state == ST_RESP) && (grant == GNT_I)) begin
        served_i <= 1'b1;
      end
    end
  end

  // Access sequencer: IDLE -> ISSUE -> WAIT -> RESP, with registered MMU-side outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      wait_cnt         <= '0;
      grant            <= GNT_D;
      mem_addr         <= '0;
      mem_request      <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_data_in      <= '0;
      timeout_error    <= 2'b00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_pending) begin
            grant       <= pick_i;
            mem_request <= 1'b1;
            if (pick_i) begin
              // fetch port never writes
              mem_addr         <= i_addr;
              mem_write_enable <= 1'b0;
              mem_data_in      <= '0;
            end else begin
              mem_addr         <= d_addr;
              mem_write_enable <= d_write_enable;
              mem_data_in      <= d_data_in;
            end
            state <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          // give the MMU one cycle to raise busy before it is sampled
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end

        ST_WAIT: begin
          if (!mem_busy) begin
            mem_request <= 1'b0;
            state       <= ST_RESP;
          end else if (wait_cnt == CNT_MAX) begin
            mem_request          <= 1'b0;
            timeout_error[grant] <= 1'b1;
            state                <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ST_RESP: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Read-data capture: completed reads land in the owner's output, aborted reads return the poison word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_out <= '0;
      i_out <= '0;
    end else if ((state == ST_WAIT) && !mem_write_enable && granted_req &&
                 (!mem_busy || (wait_cnt == CNT_MAX))) begin
      if (grant == GNT_I) begin
        i_out <= mem_busy ? ABORT_VAL : mem_out;
      end else begin
        d_out <= mem_busy ? ABORT_VAL : mem_out;
      end
    end
  end

endmodule
